press_event_adjuster: RTL and testbench

Consumer side of the plus/minus button press detector: turns short-press pulses and long-press levels into stepping of one editable alarm-clock field (minutes or hours). A short press steps the value once. A held long press steps it immediately, then auto-repeats at a fixed rate. The value wraps within 0..MAX_VALUE. One instance sits per editable field, between the press detectors and the time/alarm registers.

---
 rtl/press_event_adjuster.sv | 161 ++++++++++++++++
 tb/tb_press_event_adjuster.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/press_event_adjuster.sv
// press_event_adjuster
//   Steps one editable alarm-clock field (minutes or hours) from the press
//   detector outputs. A short press steps once. A held long press steps
//   immediately and then repeats every REPEAT_MS clocks while it is held.
//   The value wraps within 0..MAX_VALUE.
//
// Parameters
//   WIDTH      bit width of the value
//   MAX_VALUE  highest legal value (MAX_VALUE < 2**WIDTH)
//   REPEAT_MS  clocks between auto-repeat steps (>= 2)
//
// Ports
//   clk_1kHz     in   system clock, 1 ms period
//   rst          in   synchronous, active-high reset
//   edit_en      in   field selected for editing; low ignores all presses
//   plus_short   in   one-cycle pulse per short plus press
//   plus_long    in   level, high while a plus long press is held
//   minus_short  in   one-cycle pulse per short minus press
//   minus_long   in   level, high while a minus long press is held
//   load         in   one-cycle strobe that loads load_value
//   load_value   in   value to load (clamped to MAX_VALUE)
//   value        out  current field value (registered)
//   step_pulse   out  one-cycle pulse in the cycle value changed by a press
//   repeating    out  high while an auto-repeat state is active
module press_event_adjuster #(
  parameter int WIDTH     = 6,
  parameter int MAX_VALUE = 59,
  parameter int REPEAT_MS = 100
) (
  input  logic             clk_1kHz,
  input  logic             rst,
  input  logic             edit_en,
  input  logic             plus_short,
  input  logic             plus_long,
  input  logic             minus_short,
  input  logic             minus_long,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] value,
  output logic             step_pulse,
  output logic             repeating
);

  localparam int                CNT_W    = $clog2(REPEAT_MS);
  localparam logic [WIDTH-1:0]  MAX_V    = WIDTH'(MAX_VALUE);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(REPEAT_MS - 1);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    REPEAT_UP   = 2'd1,
    REPEAT_DOWN = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] value_q, value_d;
  logic             step_q, step_d;
  logic             conflict;

  function automatic logic [WIDTH-1:0] wrap_inc(input logic [WIDTH-1:0] v);
    return (v == MAX_V) ? '0 : v + WIDTH'(1);
  endfunction

  function automatic logic [WIDTH-1:0] wrap_dec(input logic [WIDTH-1:0] v);
    return (v == '0) ? MAX_V : v - WIDTH'(1);
  endfunction

  function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
    return (v > MAX_V) ? MAX_V : v;
  endfunction

  // Both directions requested at once: treat as ambiguous and cancel.
  assign conflict = (plus_short | plus_long) & (minus_short | minus_long);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    value_d = value_q;
    step_d  = 1'b0;

    if (load) begin
      value_d = clamp_load(load_value);
      state_d = IDLE;
      cnt_d   = '0;
    end else if (!edit_en || conflict) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          // Long presses win over short pulses so a held key steps
          // immediately and enters auto-repeat.
          if (plus_long) begin
            value_d = wrap_inc(value_q);
            step_d  = 1'b1;
            state_d = REPEAT_UP;
            cnt_d   = '0;
          end else if (minus_long) begin
            value_d = wrap_dec(value_q);
            step_d  = 1'b1;
            state_d = REPEAT_DOWN;
            cnt_d   = '0;
          end else if (plus_short) begin
            value_d = wrap_inc(value_q);
            step_d  = 1'b1;
          end else if (minus_short) begin
            value_d = wrap_dec(value_q);
            step_d  = 1'b1;
          end
        end
        REPEAT_UP: begin
          if (!plus_long) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            value_d = wrap_inc(value_q);
            step_d  = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        REPEAT_DOWN: begin
          if (!minus_long) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            value_d = wrap_dec(value_q);
            step_d  = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_1kHz) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      value_q <= '0;
      step_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      value_q <= value_d;
      step_q  <= step_d;
    end
  end

  assign value      = value_q;
  assign step_pulse = step_q;
  assign repeating  = (state_q != IDLE);

endmodule

// File: tb/tb_press_event_adjuster.sv
module tb_press_event_adjuster;

  localparam int WIDTH     = 6;
  localparam int MAX_VALUE = 59;
  localparam int REPEAT_MS = 100;

  logic             clk_1kHz = 1'b0;
  logic             rst = 1'b0;
  logic             edit_en = 1'b0;
  logic             plus_short = 1'b0;
  logic             plus_long = 1'b0;
  logic             minus_short = 1'b0;
  logic             minus_long = 1'b0;
  logic             load = 1'b0;
  logic [WIDTH-1:0] load_value = '0;
  logic [WIDTH-1:0] value;
  logic             step_pulse;
  logic             repeating;

  int n_pass  = 0;
  int n_total = 0;

  press_event_adjuster #(
    .WIDTH(WIDTH), .MAX_VALUE(MAX_VALUE), .REPEAT_MS(REPEAT_MS)
  ) dut (
    .clk_1kHz(clk_1kHz), .rst(rst), .edit_en(edit_en),
    .plus_short(plus_short), .plus_long(plus_long),
    .minus_short(minus_short), .minus_long(minus_long),
    .load(load), .load_value(load_value),
    .value(value), .step_pulse(step_pulse), .repeating(repeating)
  );

  always #5 clk_1kHz = ~clk_1kHz;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // Reference model: value as an integer, mode 0 idle / +1 holding plus /
  // -1 holding minus, and the edge index at which the current hold began.
  // Repeat steps land on every REPEAT_MS-th edge after that start.
  int  m_val = 0;
  int  m_mode = 0;
  int  m_start = 0;
  int  m_step = 0;
  int  t = 0;
  bit  m_valid = 0;

  function automatic int inc(input int v);
    return (v == MAX_VALUE) ? 0 : v + 1;
  endfunction
  function automatic int dec(input int v);
    return (v == 0) ? MAX_VALUE : v - 1;
  endfunction

  always @(posedge clk_1kHz) begin
    m_step = 0;
    if (rst) begin
      m_val = 0; m_mode = 0; m_valid = 1;
    end else if (load) begin
      m_val = (int'(load_value) > MAX_VALUE) ? MAX_VALUE : int'(load_value);
      m_mode = 0;
    end else if (!edit_en || ((plus_short | plus_long) && (minus_short | minus_long))) begin
      m_mode = 0;
    end else if (m_mode == 0) begin
      if (plus_long) begin
        m_val = inc(m_val); m_step = 1; m_mode = 1; m_start = t;
      end else if (minus_long) begin
        m_val = dec(m_val); m_step = 1; m_mode = -1; m_start = t;
      end else if (plus_short) begin
        m_val = inc(m_val); m_step = 1;
      end else if (minus_short) begin
        m_val = dec(m_val); m_step = 1;
      end
    end else if (m_mode == 1) begin
      if (!plus_long) m_mode = 0;
      else if ((t - m_start) % REPEAT_MS == 0) begin m_val = inc(m_val); m_step = 1; end
    end else begin
      if (!minus_long) m_mode = 0;
      else if ((t - m_start) % REPEAT_MS == 0) begin m_val = dec(m_val); m_step = 1; end
    end
    t++;
    #1;
    if (m_valid) begin
      check("value", 32'(value), 32'(m_val));
      check("step_pulse", 32'(step_pulse), 32'(m_step));
      check("repeating", 32'(repeating), 32'(m_mode != 0));
    end
  end

  // Applies one cycle of inputs, lets one edge sample them, returns after
  // the outputs have settled.
  task automatic drive(input bit r, input bit en, input bit ps, input bit pl,
                       input bit ms, input bit ml, input bit ld, input int lv);
    rst = r; edit_en = en; plus_short = ps; plus_long = pl;
    minus_short = ms; minus_long = ml; load = ld; load_value = WIDTH'(lv);
    @(posedge clk_1kHz);
    #3;
  endtask

  bit r_pl, r_ml;

  initial begin
    #2;
    // Reset
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    check("lit_reset_value", 32'(value), 0);
    check("lit_reset_rep", 32'(repeating), 0);

    // Back-to-back short pulses
    repeat (3) drive(0, 1, 1, 0, 0, 0, 0, 0);
    check("lit_short3", 32'(value), 3);

    // Wrap around both ends
    drive(0, 1, 0, 0, 0, 0, 1, 59);
    check("lit_load59", 32'(value), 59);
    drive(0, 1, 1, 0, 0, 0, 0, 0);
    check("lit_wrap_up", 32'(value), 0);
    drive(0, 1, 0, 0, 1, 0, 0, 0);
    check("lit_wrap_down", 32'(value), 59);

    // Long press held 350 cycles from 10: steps at 0,100,200,300
    drive(0, 1, 0, 0, 0, 0, 1, 10);
    repeat (350) drive(0, 1, 0, 1, 0, 0, 0, 0);
    check("lit_long_value", 32'(value), 14);
    check("lit_long_rep", 32'(repeating), 1);
    drive(0, 1, 0, 0, 0, 0, 0, 0);
    check("lit_release_rep", 32'(repeating), 0);
    check("lit_release_value", 32'(value), 14);

    // Conflict during REPEAT_UP, then minus_long alone starts a new hold
    drive(0, 1, 0, 0, 0, 0, 1, 20);
    repeat (150) drive(0, 1, 0, 1, 0, 0, 0, 0);
    check("lit_hold150", 32'(value), 22);
    repeat (5) drive(0, 1, 0, 1, 0, 1, 0, 0);
    check("lit_conflict_value", 32'(value), 22);
    check("lit_conflict_rep", 32'(repeating), 0);
    drive(0, 1, 0, 0, 0, 1, 0, 0);
    check("lit_minus_alone", 32'(value), 21);
    drive(0, 1, 0, 0, 0, 0, 0, 0);

    // Editing disabled
    drive(0, 0, 1, 0, 0, 0, 0, 0);
    repeat (10) drive(0, 0, 0, 1, 0, 0, 0, 0);
    check("lit_disabled", 32'(value), 21);

    // Load clamp and load priority over a press
    drive(0, 1, 0, 0, 0, 0, 1, 63);
    check("lit_clamp", 32'(value), 59);
    drive(0, 1, 1, 0, 0, 0, 1, 5);
    check("lit_load_press", 32'(value), 5);
    check("lit_load_nostep", 32'(step_pulse), 0);

    // Reset mid-repeat
    repeat (50) drive(0, 1, 0, 1, 0, 0, 0, 0);
    check("lit_pre_rst", 32'(value), 6);
    drive(1, 1, 0, 1, 0, 0, 0, 0);
    check("lit_rst_mid", 32'(value), 0);
    check("lit_rst_nostep", 32'(step_pulse), 0);

    // Randomized traffic
    r_pl = 0; r_ml = 0;
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 149) == 0) r_pl = ~r_pl;
      if ($urandom_range(0, 149) == 0) r_ml = ~r_ml;
      drive($urandom_range(0, 999) == 0,
            $urandom_range(0, 19) != 0,
            $urandom_range(0, 7) == 0,
            r_pl,
            $urandom_range(0, 7) == 0,
            r_ml,
            $urandom_range(0, 79) == 0,
            int'($urandom_range(0, 63)));
    end

    drive(0, 1, 0, 0, 0, 0, 0, 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
